// File: rtl/fetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// fetch_queue_pkg
// Shared definitions for the fetch queue: field widths, the packed entry
// layout and helpers that pack the fetch bundle fields into one entry vector.
//
// Entry layout (MSB .. LSB), 131 bits total:
//   [130:99] IR          instruction word
//   [98:67]  PC          sequential next PC
//   [66:35]  InstrAddr   address of the instruction
//   [34:3]   Predict     predicted target
//   [2]      PCSource    predict-taken flag
//   [1:0]    CB          prediction counter bits
// ---------------------------------------------------------------------------
package fetch_queue_pkg;

    localparam int IR_W    = 32;
    localparam int ADDR_W  = 32;
    localparam int CB_W    = 2;
    localparam int ENTRY_W = IR_W + 3 * ADDR_W + 1 + CB_W;

    // Bit offsets of each field inside an entry
    localparam int CB_LSB    = 0;
    localparam int PCSRC_BIT = CB_LSB + CB_W;
    localparam int PRED_LSB  = PCSRC_BIT + 1;
    localparam int IADDR_LSB = PRED_LSB + ADDR_W;
    localparam int PC_LSB    = IADDR_LSB + ADDR_W;
    localparam int IR_LSB    = PC_LSB + ADDR_W;

    typedef logic [ENTRY_W-1:0] entry_t;

    // Pack the individual bundle fields into a single entry vector
    function automatic entry_t pack_entry(
        input logic [IR_W-1:0]   ir,
        input logic [ADDR_W-1:0] pc,
        input logic [ADDR_W-1:0] instr_addr,
        input logic [ADDR_W-1:0] predict,
        input logic              pc_source,
        input logic [CB_W-1:0]   cb
    );
        entry_t e;
        e = {ENTRY_W{1'b0}};
        e[IR_LSB    +: IR_W]   = ir;
        e[PC_LSB    +: ADDR_W] = pc;
        e[IADDR_LSB +: ADDR_W] = instr_addr;
        e[PRED_LSB  +: ADDR_W] = predict;
        e[PCSRC_BIT]           = pc_source;
        e[CB_LSB    +: CB_W]   = cb;
        return e;
    endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// ---------------------------------------------------------------------------
// fetch_queue_mem
// DEPTH x ENTRY_W register array backing the fetch queue. One synchronous
// write port and one asynchronous (combinational) read port. The whole array
// is cleared to zero by the asynchronous active-low reset so that the queue
// outputs read as zero after reset.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset, clears all entries
//   we     in   write enable
//   waddr  in   write address (AW bits)
//   wdata  in   write data (ENTRY_W bits)
//   raddr  in   read address (AW bits)
//   rdata  out  entry at raddr
// ---------------------------------------------------------------------------
module fetch_queue_mem
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] mem_r [DEPTH];

    // Storage array: cleared on reset, written on we
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {ENTRY_W{1'b0}};
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Instruction buffer between fetch and decode. Accepts one fetch bundle per
// cycle (Push = InValid & InReady) and presents bundles to decode in order
// (Pop = OutValid & OutReady). Raises Full as a stall request when all
// DEPTH entries are occupied and discards its contents on Flush.
//
// InReady, Full and (in the default build) OutValid come straight from
// registers, so there is no combinational path from OutReady to InReady and a
// pop does not make room for a push in the same cycle when full.
//
// Optional build macro FETCH_QUEUE_BYPASS_EN: when the queue is empty and a
// bundle arrives without Flush, it is presented on the outputs in the same
// cycle; if decode takes it, it is never written into the storage.
//
// Ports:
//   Clk, Rst      clock (rising edge) and asynchronous active-low reset
//   Flush         synchronous flush, highest priority
//   InValid/InReady, InIR, InPC, InInstrAddr, InPredict, InPCSource, InCB
//                 fetch side bundle and handshake
//   OutValid/OutReady, IR, PC, InstrAddr, Predict, PCSource, CB
//                 decode side bundle and handshake (head entry)
//   Full          occupancy == DEPTH
//   Count         occupancy (AW+1 bits)
// ---------------------------------------------------------------------------
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Flush,
    input  logic              InValid,
    output logic              InReady,
    input  logic [IR_W-1:0]   InIR,
    input  logic [ADDR_W-1:0] InPC,
    input  logic [ADDR_W-1:0] InInstrAddr,
    input  logic [ADDR_W-1:0] InPredict,
    input  logic              InPCSource,
    input  logic [CB_W-1:0]   InCB,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [IR_W-1:0]   IR,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] InstrAddr,
    output logic [ADDR_W-1:0] Predict,
    output logic              PCSource,
    output logic [CB_W-1:0]   CB,
    output logic              Full,
    output logic [AW:0]       Count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ZERO_CNT = (AW+1)'(0);

    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_nxt_s;
    logic [AW-1:0] wr_ptr_nxt_s;
    logic [AW:0]   count_r;
    logic [AW:0]   count_nxt_s;
    logic          full_r;
    logic          nonempty_r;

    logic          push_s;
    logic          pop_s;
    logic          wr_en_s;
    logic          rd_en_s;
    logic          out_valid_s;
    entry_t        in_entry_s;
    entry_t        rd_entry_s;
    entry_t        out_entry_s;

    assign in_entry_s = pack_entry(InIR, InPC, InInstrAddr, InPredict, InPCSource, InCB);

    // Acceptance depends only on registered occupancy
    assign push_s = InValid & ~full_r;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass_s;
    logic bypass_take_s;

    // Empty queue with an incoming bundle: forward it to decode this cycle.
    // Flush suppresses the bypass, so OutValid is 0 in a Flush cycle when empty.
    assign bypass_s      = ~nonempty_r & InValid & ~Flush;
    assign bypass_take_s = bypass_s & OutReady;
    assign out_valid_s   = nonempty_r | bypass_s;
    assign out_entry_s   = bypass_s ? in_entry_s : rd_entry_s;
    assign pop_s         = out_valid_s & OutReady;
    // A bundle consumed through the bypass never touches storage or pointers
    assign wr_en_s       = push_s & ~Flush & ~bypass_take_s;
    assign rd_en_s       = pop_s & nonempty_r & ~Flush;
`else
    assign out_valid_s   = nonempty_r;
    assign out_entry_s   = rd_entry_s;
    assign pop_s         = out_valid_s & OutReady;
    assign wr_en_s       = push_s & ~Flush;
    assign rd_en_s       = pop_s & ~Flush;
`endif

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (Clk),
        .rst_n (Rst),
        .we    (wr_en_s),
        .waddr (wr_ptr_r),
        .wdata (in_entry_s),
        .raddr (rd_ptr_r),
        .rdata (rd_entry_s)
    );

    // Next pointer / occupancy; Flush overrides any push or pop
    always_comb begin
        rd_ptr_nxt_s = rd_ptr_r;
        wr_ptr_nxt_s = wr_ptr_r;
        count_nxt_s  = count_r;
        if (Flush) begin
            rd_ptr_nxt_s = {AW{1'b0}};
            wr_ptr_nxt_s = {AW{1'b0}};
            count_nxt_s  = ZERO_CNT;
        end else begin
            if (wr_en_s) begin
                wr_ptr_nxt_s = wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (rd_en_s) begin
                rd_ptr_nxt_s = rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            // Push is blocked at full and pop at empty, so no overflow here
            case ({wr_en_s, rd_en_s})
                2'b10:   count_nxt_s = count_r + (AW+1)'(1);
                2'b01:   count_nxt_s = count_r - (AW+1)'(1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // State registers; full/nonempty flags precomputed from next occupancy
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            count_r    <= ZERO_CNT;
            full_r     <= 1'b0;
            nonempty_r <= 1'b0;
        end else begin
            rd_ptr_r   <= rd_ptr_nxt_s;
            wr_ptr_r   <= wr_ptr_nxt_s;
            count_r    <= count_nxt_s;
            full_r     <= (count_nxt_s == FULL_CNT);
            nonempty_r <= (count_nxt_s != ZERO_CNT);
        end
    end

    assign InReady   = ~full_r;
    assign Full      = full_r;
    assign Count     = count_r;
    assign OutValid  = out_valid_s;

    assign IR        = out_entry_s[IR_LSB    +: IR_W];
    assign PC        = out_entry_s[PC_LSB    +: ADDR_W];
    assign InstrAddr = out_entry_s[IADDR_LSB +: ADDR_W];
    assign Predict   = out_entry_s[PRED_LSB  +: ADDR_W];
    assign PCSource  = out_entry_s[PCSRC_BIT];
    assign CB        = out_entry_s[CB_LSB    +: CB_W];

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer between fetch and decode.
- Captures one fetched bundle per cycle: instruction word, PC, instruction address, predicted target, predict-taken flag and 2-bit counter.
- Presents bundles to decode in order through a valid/ready handshake.
- Decouples fetch from decode stalls, raises back-pressure when full, and discards all contents on a pipeline flush.

Parameters:
- DEPTH, 4, number of entries; power of two, >=2.
- AW, 2, pointer width = log2(DEPTH).

Ports:
- Clk  in  1  single clock, rising edge.
- Rst  in  1  asynchronous, active-low reset (0 = reset).
- Flush  in  1  hazard-unit flush; discards all entries.
- InValid  in  1  fetch bundle valid (no Imiss, fetch not stalled).
- InReady  out  1  queue can accept a bundle.
- InIR  in  32  instruction word.
- InPC  in  32  sequential next PC.
- InInstrAddr  in  32  address of the instruction.
- InPredict  in  32  predicted target.
- InPCSource  in  1  predict-taken flag.
- InCB  in  2  prediction counter bits.
- OutValid  out  1  head entry valid.
- OutReady  in  1  decode accepts the head (decode not stalled).
- IR  out  32  head instruction word.
- PC  out  32  head sequential next PC.
- InstrAddr  out  32  head instruction address.
- Predict  out  32  head predicted target.
- PCSource  out  1  head predict-taken flag.
- CB  out  2  head prediction counter bits.
- Full  out  1  count==DEPTH; stall request to hazard unit.
- Count  out  AW+1  occupancy.

Behaviour:
- Entry width is 131 bits: IR, PC, InstrAddr, Predict, PCSource, CB.
- Push = InValid & InReady. Pop = OutValid & OutReady.
- InReady = (Count != DEPTH). It is derived from registered state only and has no combinational path from OutReady. A pop in the same cycle does not free space for a push when full.
- OutValid = (Count != 0). Output data are driven from the entry at the read pointer.
- Latency: a bundle pushed at edge N is visible with OutValid=1 after edge N.
- Simultaneous push and pop: Count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Count is AW+1 bits and saturates structurally because push is blocked at full and pop is blocked at empty.
- Flush (synchronous, highest priority):
  - Next edge sets Count=0 and both pointers to 0.
  - A push or pop in the same cycle is ignored.
  - Storage contents are not cleared.
  - In the Flush cycle itself, OutValid and InReady still reflect the pre-flush state.
- Reset (Rst low, asynchronous, also mid-operation):
  - Count=0, pointers=0, all storage=0.
  - Hence OutValid=0, Full=0, InReady=1.
  - IR, PC, InstrAddr and Predict = 0; PCSource=0; CB=2'b00.
- The outputs hold their value while OutValid=1 and OutReady=0.
- There is no other state machine; the state is (rd_ptr, wr_ptr, Count).

Optional Feature:
- Macro FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When Count==0 and InValid=1 and Flush=0, OutValid=1 in the same cycle and the output fields take the In* values combinationally.
  - If OutReady=1 that cycle, the bundle is consumed and not written; Count stays 0.
  - Otherwise it is written normally.
  - OutValid is forced 0 during any Flush cycle when empty.
- Undefined: strict 1-cycle latency as described above, with no combinational In-to-Out path.

Decomposition:
- Shared header (`include) holds:
  - Field widths: IR_W=32, ADDR_W=32, CB_W=2.
  - ENTRY_W=131.
  - Field bit offsets used to pack and unpack the entry vector.
- One sub-module, fetch_queue_mem:
  - DEPTH x ENTRY_W register array.
  - One write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
  - Asynchronously reset to zero by Rst.
- Pointer and count control stays in fetch_queue.

Test Plan:
- Reset: Rst=0 mid-stream with Count=3 -> immediately OutValid=0, Count=0, InReady=1, IR=0, CB=0. After release, first push InIR=0x20010005 appears at IR one cycle later.
- Fill and drain: OutReady=0, push 4 bundles (InstrAddr 0x100, 0x104, 0x108, 0x10C) -> Full=1, InReady=0, fifth push ignored. Then OutReady=1 -> pops in order 0x100 to 0x10C, OutValid=0 after the fourth pop.
- Simultaneous push and pop at Count=2 for 10 cycles -> Count stays 2, order preserved across pointer wrap.
- Full with OutReady=1 and InValid=1 -> pop occurs, push refused (InReady=0). Next cycle Count=3, InReady=1.
- Flush at Count=3 with a concurrent push -> next cycle Count=0, OutValid=0. The pushed bundle (InPredict=0x400, InPCSource=1, InCB=2'b11) never appears.
- With FETCH_QUEUE_BYPASS_EN: empty queue, InValid=1, OutReady=1, InIR=0xDEADBEEF -> IR=0xDEADBEEF and OutValid=1 in the same cycle, Count remains 0.
